instruction_fetch: RTL and testbench

- Fetch stage of the uDLX 5-stage pipeline, directly upstream of `instruction_decoder`.
- Owns the PC and issues requests to instruction memory over a req/ready handshake.
- Holds the IF/ID pipeline register whose `instruction_out` drives `instruction_in` of the decoder.
- Supports hazard stall, branch/jump redirect with flush, and a one-entry skid buffer so no completed fetch is lost during a stall.

---
 rtl/instruction_fetch_pkg.sv | 12 +
 rtl/instruction_fetch_if_id_register.sv | 44 ++++
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the uDLX fetch stage: FSM encodings and default bubble/increment values.
package instruction_fetch_pkg;

    typedef logic fetch_state_t;

    localparam fetch_state_t FETCH_ST   = 1'b0;
    localparam fetch_state_t DISCARD_ST = 1'b1;

    localparam logic [31:0] DEFAULT_NOP_INSTRUCTION = 32'h0000_0000;
    localparam int unsigned DEFAULT_PC_INCREMENT    = 4;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: flush beats load, otherwise contents hold.
module if_id_register
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned                  PC_WIDTH          = 32,
    parameter int unsigned                  INSTRUCTION_WIDTH = 32,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = DEFAULT_NOP_INSTRUCTION
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_load,
    input  logic [INSTRUCTION_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]          i_pc4,
    output logic [INSTRUCTION_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]          o_pc4,
    output logic                         o_valid
);

    logic [INSTRUCTION_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]          r_pc4;
    logic                         r_valid;

    // A flush keeps pc_plus4 so the decoder's PC view only moves on real loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTRUCTION;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTRUCTION;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch.sv
// uDLX fetch stage: PC, imem req/ready handshake, one-entry skid buffer and branch DISCARD FSM.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned                  PC_WIDTH          = 32,
    parameter int unsigned                  INSTRUCTION_WIDTH = 32,
    parameter int unsigned                  PC_INCREMENT      = DEFAULT_PC_INCREMENT,
    parameter logic [PC_WIDTH-1:0]          RESET_PC          = '0,
    parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = DEFAULT_NOP_INSTRUCTION
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall_in,
    input  logic                         branch_taken_in,
    input  logic [PC_WIDTH-1:0]          branch_target_in,
    output logic [PC_WIDTH-1:0]          imem_addr_out,
    output logic                         imem_req_out,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
    input  logic                         imem_ready_in,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]          pc_plus4_out,
    output logic                         valid_out
);

    logic [PC_WIDTH-1:0]          r_pc;
    fetch_state_t                 r_state;
    logic                         r_req;
    logic [PC_WIDTH-1:0]          r_target;
    logic                         r_skid_valid;
    logic [INSTRUCTION_WIDTH-1:0] r_skid_instr;
    logic [PC_WIDTH-1:0]          r_skid_pc4;

    logic [PC_WIDTH-1:0]          w_pc_d;
    fetch_state_t                 w_state_d;
    logic [PC_WIDTH-1:0]          w_target_d;
    logic                         w_skid_valid_d;
    logic [INSTRUCTION_WIDTH-1:0] w_skid_instr_d;
    logic [PC_WIDTH-1:0]          w_skid_pc4_d;
    logic                         w_xfer;
    logic [PC_WIDTH-1:0]          w_pc_inc;
    logic                         w_ifid_load;
    logic                         w_ifid_flush;
    logic [INSTRUCTION_WIDTH-1:0] w_ifid_instr;
    logic [PC_WIDTH-1:0]          w_ifid_pc4;

    assign w_xfer   = r_req & imem_ready_in;
    assign w_pc_inc = r_pc + PC_WIDTH'(PC_INCREMENT);

    always_comb begin
        w_pc_d         = r_pc;
        w_state_d      = r_state;
        w_target_d     = r_target;
        w_skid_valid_d = r_skid_valid;
        w_skid_instr_d = r_skid_instr;
        w_skid_pc4_d   = r_skid_pc4;
        w_ifid_load    = 1'b0;
        w_ifid_flush   = 1'b0;
        w_ifid_instr   = imem_data_in;
        w_ifid_pc4     = w_pc_inc;

        if (branch_taken_in) begin
            w_ifid_flush   = 1'b1;
            w_skid_valid_d = 1'b0;
            // A pending access must finish at its held address before we may redirect.
            if (r_req && !imem_ready_in) begin
                w_state_d  = DISCARD_ST;
                w_target_d = branch_target_in;
            end else begin
                w_state_d = FETCH_ST;
                w_pc_d    = branch_target_in;
            end
        end else if (r_state == DISCARD_ST) begin
            if (w_xfer) begin
                w_state_d = FETCH_ST;
                w_pc_d    = r_target;
            end
            if (!stall_in) begin
                w_ifid_flush = 1'b1;
            end
        end else if (r_skid_valid) begin
            if (!stall_in) begin
                w_ifid_load    = 1'b1;
                w_ifid_instr   = r_skid_instr;
                w_ifid_pc4     = r_skid_pc4;
                w_skid_valid_d = 1'b0;
            end
        end else if (w_xfer) begin
            w_pc_d = w_pc_inc;
            if (stall_in) begin
                w_skid_valid_d = 1'b1;
                w_skid_instr_d = imem_data_in;
                w_skid_pc4_d   = w_pc_inc;
            end else begin
                w_ifid_load = 1'b1;
            end
        end else if (!stall_in) begin
            w_ifid_flush = 1'b1;
        end
    end

    // Request is withheld only while the skid buffer holds a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_state      <= FETCH_ST;
            r_req        <= 1'b0;
            r_target     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= NOP_INSTRUCTION;
            r_skid_pc4   <= '0;
        end else begin
            r_pc         <= w_pc_d;
            r_state      <= w_state_d;
            r_req        <= !w_skid_valid_d;
            r_target     <= w_target_d;
            r_skid_valid <= w_skid_valid_d;
            r_skid_instr <= w_skid_instr_d;
            r_skid_pc4   <= w_skid_pc4_d;
        end
    end

    assign imem_addr_out = r_pc;
    assign imem_req_out  = r_req;

    if_id_register #(
        .PC_WIDTH          (PC_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
        .NOP_INSTRUCTION   (NOP_INSTRUCTION)
    ) u_if_id_register (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_ifid_flush),
        .i_load  (w_ifid_load),
        .i_instr (w_ifid_instr),
        .i_pc4   (w_ifid_pc4),
        .o_instr (instruction_out),
        .o_pc4   (pc_plus4_out),
        .o_valid (valid_out)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a zero-wait memory returning addr ^ 32'hA5A5_0000.
module tb_instruction_fetch;

    localparam logic [31:0] MEM_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_target_in;
    logic [31:0] imem_addr_out;
    logic        imem_req_out;
    logic [31:0] imem_data_in;
    logic        imem_ready_in;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;

    int n_vec = 0;
    int n_err = 0;

    instruction_fetch u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .imem_addr_out    (imem_addr_out),
        .imem_req_out     (imem_req_out),
        .imem_data_in     (imem_data_in),
        .imem_ready_in    (imem_ready_in),
        .instruction_out  (instruction_out),
        .pc_plus4_out     (pc_plus4_out),
        .valid_out        (valid_out)
    );

    assign imem_data_in = imem_addr_out ^ MEM_KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the memory side and IF/ID validity/word after the current edge.
    task automatic expect_if(input string tag, input logic [31:0] addr, input logic req,
                             input logic [31:0] instr, input logic valid);
        check_vec({tag, ".addr"}, imem_addr_out, addr);
        check_vec({tag, ".req"}, {31'd0, imem_req_out}, {31'd0, req});
        check_vec({tag, ".instr"}, instruction_out, instr);
        check_vec({tag, ".valid"}, {31'd0, valid_out}, {31'd0, valid});
    endtask

    initial begin
        rst_n            = 1'b0;
        stall_in         = 1'b0;
        branch_taken_in  = 1'b0;
        branch_target_in = 32'h0;
        imem_ready_in    = 1'b1;
        tick();
        tick();
        expect_if("reset", 32'h0, 1'b0, 32'h0, 1'b0);
        check_vec("reset.pc4", pc_plus4_out, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_if("e1", 32'h0, 1'b1, 32'h0, 1'b0);
        tick();
        expect_if("e2", 32'h4, 1'b1, 32'hA5A5_0000, 1'b1);
        check_vec("e2.pc4", pc_plus4_out, 32'h4);
        tick();
        expect_if("e3", 32'h8, 1'b1, 32'hA5A5_0004, 1'b1);
        check_vec("e3.pc4", pc_plus4_out, 32'h8);

        // Memory wait states at address 8.
        imem_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_if("wait", 32'h8, 1'b1, 32'h0, 1'b0);
        end
        imem_ready_in = 1'b1;
        tick();
        expect_if("wait_done", 32'hC, 1'b1, 32'hA5A5_0008, 1'b1);
        tick();
        expect_if("seq12", 32'h10, 1'b1, 32'hA5A5_000C, 1'b1);

        // Stall while word@16 completes: captured in the skid buffer.
        stall_in = 1'b1;
        tick();
        expect_if("stall1", 32'h14, 1'b0, 32'hA5A5_000C, 1'b1);
        check_vec("stall1.pc4", pc_plus4_out, 32'h10);
        tick();
        expect_if("stall2", 32'h14, 1'b0, 32'hA5A5_000C, 1'b1);
        stall_in = 1'b0;
        tick();
        expect_if("drain", 32'h14, 1'b1, 32'hA5A5_0010, 1'b1);
        check_vec("drain.pc4", pc_plus4_out, 32'h14);
        tick();
        expect_if("post_drain", 32'h18, 1'b1, 32'hA5A5_0014, 1'b1);

        // Redirect in the same cycle word@24 completes.
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h100;
        tick();
        branch_taken_in = 1'b0;
        expect_if("br_same", 32'h100, 1'b1, 32'h0, 1'b0);
        tick();
        expect_if("br_tgt", 32'h104, 1'b1, 32'hA5A5_0100, 1'b1);
        check_vec("br_tgt.pc4", pc_plus4_out, 32'h104);

        // Get to address 40, then redirect while its access is pending.
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h28;
        tick();
        branch_taken_in = 1'b0;
        imem_ready_in   = 1'b0;
        expect_if("to40", 32'h28, 1'b1, 32'h0, 1'b0);
        tick();
        expect_if("pend40", 32'h28, 1'b1, 32'h0, 1'b0);
        branch_taken_in  = 1'b1;
        branch_target_in = 32'h200;
        tick();
        branch_taken_in = 1'b0;
        expect_if("disc1", 32'h28, 1'b1, 32'h0, 1'b0);
        tick();
        expect_if("disc2", 32'h28, 1'b1, 32'h0, 1'b0);
        imem_ready_in = 1'b1;
        tick();
        expect_if("disc_drop", 32'h200, 1'b1, 32'h0, 1'b0);
        tick();
        expect_if("disc_tgt", 32'h204, 1'b1, 32'hA5A5_0200, 1'b1);

        // Fill the skid buffer, then reset mid-stall.
        stall_in = 1'b1;
        tick();
        expect_if("skid_fill", 32'h208, 1'b0, 32'hA5A5_0200, 1'b1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        expect_if("rst_async", 32'h0, 1'b0, 32'h0, 1'b0);
        check_vec("rst_async.pc4", pc_plus4_out, 32'h0);
        stall_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_if("rst_e1", 32'h0, 1'b1, 32'h0, 1'b0);
        tick();
        expect_if("rst_e2", 32'h4, 1'b1, 32'hA5A5_0000, 1'b1);

        // PC wrap at the top of the address space.
        branch_taken_in  = 1'b1;
        branch_target_in = 32'hFFFF_FFFC;
        tick();
        branch_taken_in = 1'b0;
        expect_if("wrap_tgt", 32'hFFFF_FFFC, 1'b1, 32'h0, 1'b0);
        tick();
        expect_if("wrap", 32'h0, 1'b1, 32'h5A5A_FFFC, 1'b1);
        check_vec("wrap.pc4", pc_plus4_out, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
